and16_vector_checker: RTL and testbench

- Synthesizable self-checking sequencer for the 16-bit AND datapath.
- Drives operand vectors a = index, b = constant into a DUT and waits a fixed settle time.
- Reads back the DUT result, compares it against a & b, and streams one record per vector to a logger over a valid/ready handshake.
- Accumulates a mismatch count and first-failure index; gives on-chip pass/fail for the gate-level CPU blocks.

---
 rtl/and16_chk_pkg.sv | 23 ++
 rtl/and16_vector_checker_sat_counter.sv | 18 +
 rtl/and16_vector_checker.sv | 129 ++++++++++++
 tb/tb_and16_vector_checker.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/and16_chk_pkg.sv
// and16_chk_pkg: FSM encoding, default operand constant and sizing helper
// shared by the AND16 vector checker.
package and16_chk_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_DRIVE  = 3'd1;
    localparam state_t S_SETTLE = 3'd2;
    localparam state_t S_CHECK  = 3'd3;
    localparam state_t S_EMIT   = 3'd4;
    localparam state_t S_DONE   = 3'd5;

    localparam logic [15:0] B_CONST_DEFAULT = 16'h00FF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/and16_vector_checker_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (clr) count <= '0;
        else if (en && !(&count)) count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/and16_vector_checker.sv
// and16_vector_checker: drives index/constant vectors into an AND datapath,
// compares the settled result against a & b and streams one record per vector.
module and16_vector_checker
    import and16_chk_pkg::*;
#(
    parameter int               WIDTH         = 16,
    parameter int               NUM_VECTORS   = 256,
    parameter logic [WIDTH-1:0] B_CONST       = WIDTH'(B_CONST_DEFAULT),
    parameter int               SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    input  logic [WIDTH-1:0] dut_out,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [WIDTH-1:0] rec_a,
    output logic [WIDTH-1:0] rec_b,
    output logic [WIDTH-1:0] rec_out,
    output logic             rec_mismatch,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] err_count,
    output logic [WIDTH-1:0] first_err_idx,
    output logic             first_err_valid
);

    // One spare index bit keeps the last-vector compare wrap-free at 2**WIDTH vectors.
    localparam int            IW   = clog2(NUM_VECTORS) + 1;
    localparam int            SW   = clog2(SETTLE_CYCLES + 1) + 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_VECTORS - 1);

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic [SW-1:0] settle_cnt;
    logic          run_start, fire, last, mismatch, err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: state_nx = start ? S_DRIVE : state;
            S_DRIVE:        state_nx = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE:       state_nx = (settle_cnt <= SW'(1)) ? S_CHECK : S_SETTLE;
            S_CHECK:        state_nx = S_EMIT;
            S_EMIT:         state_nx = fire ? (last ? S_DONE : S_DRIVE) : S_EMIT;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        run_start = ((state == S_IDLE) || (state == S_DONE)) && start;
        fire      = (state == S_EMIT) && rec_valid && rec_ready;
        last      = idx == LAST;
        mismatch  = dut_out != (dut_a & dut_b);
        err_inc   = (state == S_CHECK) && mismatch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            settle_cnt      <= '0;
            dut_a           <= '0;
            dut_b           <= '0;
            rec_valid       <= 1'b0;
            rec_a           <= '0;
            rec_b           <= '0;
            rec_out         <= '0;
            rec_mismatch    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            if (run_start) begin
                idx             <= '0;
                busy            <= 1'b1;
                done            <= 1'b0;
                pass            <= 1'b0;
                first_err_idx   <= '0;
                first_err_valid <= 1'b0;
            end
            if (state == S_DRIVE) begin
                dut_a      <= WIDTH'(idx);
                dut_b      <= B_CONST;
                settle_cnt <= SW'(SETTLE_CYCLES);
            end
            if (state == S_SETTLE) settle_cnt <= settle_cnt - SW'(1);
            if (state == S_CHECK) begin
                rec_a        <= dut_a;
                rec_b        <= dut_b;
                rec_out      <= dut_out;
                rec_mismatch <= mismatch;
                rec_valid    <= 1'b1;
                if (mismatch && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_idx   <= WIDTH'(idx);
                end
            end
            if (fire) begin
                rec_valid <= 1'b0;
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= err_count == '0;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

    sat_counter #(.WIDTH(WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (run_start),
        .en    (err_inc),
        .count (err_count)
    );

endmodule

// File: tb/tb_and16_vector_checker.sv
// tb_and16_vector_checker: scoreboard bench with a faultable AND model,
// random backpressure and a single-vector zero-settle instance.
module tb_and16_vector_checker;

    localparam logic [15:0] B = 16'h00FF;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, rec_ready = 1'b1;
    logic [15:0] dut_a, dut_b, dut_out, rec_a, rec_b, rec_out, err_count, first_err_idx;
    logic        rec_valid, rec_mismatch, busy, done, pass, first_err_valid;
    logic [15:0] stuck0 = '0, stuck1 = '0;

    logic        s_start = 1'b0, s_ready = 1'b1;
    logic [15:0] s_dut_a, s_dut_b, s_dut_out, s_rec_a, s_rec_b, s_rec_out, s_err_count, s_first_err_idx;
    logic        s_rec_valid, s_rec_mismatch, s_busy, s_done, s_pass, s_first_err_valid;

    logic [48:0] exp_q[$];
    int          n_pass = 0, n_total = 0, nrec = 0, stalls = 0, errs = 0, first = -1;
    int          bp = 0, hold_idx = -1, hold_cnt = 0, cyc;
    longint      t0;

    always #5 clk = ~clk;

    assign dut_out   = ((dut_a & dut_b) & ~stuck0) | stuck1;
    assign s_dut_out = s_dut_a & s_dut_b;

    and16_vector_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_a(dut_a), .dut_b(dut_b), .dut_out(dut_out),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_a(rec_a), .rec_b(rec_b), .rec_out(rec_out),
        .rec_mismatch(rec_mismatch), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_valid(first_err_valid)
    );

    and16_vector_checker #(.NUM_VECTORS(1), .SETTLE_CYCLES(0)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .dut_a(s_dut_a), .dut_b(s_dut_b), .dut_out(s_dut_out),
        .rec_valid(s_rec_valid), .rec_ready(s_ready), .rec_a(s_rec_a), .rec_b(s_rec_b), .rec_out(s_rec_out),
        .rec_mismatch(s_rec_mismatch), .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err_count),
        .first_err_idx(s_first_err_idx), .first_err_valid(s_first_err_valid)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Logger: stalls either on the directed index or at random with bp percent.
    always @(posedge clk) begin
        #1;
        if (hold_idx >= 0 && rec_valid && rec_a == 16'(hold_idx) && hold_cnt < 10) begin
            rec_ready = 1'b0;
            hold_cnt++;
        end else begin
            rec_ready = $urandom_range(99) >= bp;
        end
    end

    always @(negedge clk) begin
        if (rst_n && rec_valid && !rec_ready) begin
            stalls++;
            if (exp_q.size() > 0) chk("stall_hold", {rec_a, dut_a}, {exp_q[0][48:33], exp_q[0][48:33]});
        end
        if (rst_n && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) chk("unexpected_record", {rec_a, rec_out}, '0);
            else begin
                chk("record", {rec_a, rec_b, rec_out, rec_mismatch}, exp_q.pop_front());
                nrec++;
            end
        end
    end

    // Reference: record i carries a=i, b=B and the faulty AND output.
    task automatic push_run(input logic [15:0] s0, input logic [15:0] s1);
        logic [15:0] a, o;
        logic        m;
        errs  = 0;
        first = -1;
        for (int i = 0; i < 256; i++) begin
            a = 16'(i);
            o = ((a & B) & ~s0) | s1;
            m = o != (a & B);
            exp_q.push_back({a, B, o, m});
            if (m) begin
                errs++;
                if (first < 0) first = i;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n > 20000) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        cyc = int'(($time - t0 - 5) / 10);
    endtask

    task automatic end_checks(input int cycles_exp);
        chk("cycles", cyc, cycles_exp);
        chk("err_count", err_count, errs);
        chk("first_err_valid", first_err_valid, first >= 0);
        chk("first_err_idx", first_err_idx, (first >= 0) ? first : 0);
        chk("pass", pass, errs == 0);
        chk("records", nrec, 256);
        chk("busy_done", {busy, done}, 2'b01);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run(input logic [15:0] s0, input logic [15:0] s1, input int bpp, input int hidx);
        stuck0   = s0;
        stuck1   = s1;
        bp       = bpp;
        hold_idx = hidx;
        hold_cnt = 0;
        push_run(s0, s1);
        nrec   = 0;
        stalls = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        t0 = $time;
        #1 start = 1'b0;
        wait_done();
        end_checks(1280 + stalls);
    endtask

    task automatic zero_chk(input string name);
        chk(name, {dut_a, dut_b, rec_a, rec_b, rec_out, err_count, first_err_idx,
                   rec_valid, rec_mismatch, busy, done, pass, first_err_valid}, '0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        zero_chk("reset_state");
        chk("small_reset_state", {s_dut_a, s_dut_b, s_rec_valid, s_busy, s_done, s_pass}, '0);
        rst_n = 1'b1;

        run(16'h0000, 16'h0000, 0, -1);
        run(16'h0008, 16'h0000, 0, -1);
        chk("stuck3_err", {err_count, first_err_idx}, {16'd128, 16'd8});
        run(16'h0000, 16'h0000, 0, 5);
        chk("bp_stalls", {stalls, cyc}, {32'd10, 32'd1290});
        run(16'($urandom_range(255)), 16'h0000, 30, -1);
        run(16'h0000, 16'(1) << $urandom_range(15), 20, -1);

        // Abort mid-run with a one-cycle reset.
        bp = 0;
        hold_idx = -1;
        stuck0 = '0;
        stuck1 = '0;
        push_run(16'h0000, 16'h0000);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 0; n < 2000 && dut_a != 16'd100; n++) @(negedge clk);
        chk("reached_vec100", dut_a, 16'd100);
        #2 rst_n = 1'b0;
        #1 zero_chk("mid_run_reset");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        run(16'h0000, 16'h0000, 0, -1);

        // start held high across a whole run, then an immediate restart.
        push_run(16'h0000, 16'h0000);
        nrec = 0;
        stalls = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        t0 = $time;
        wait_done();
        end_checks(1280);
        push_run(16'h0000, 16'h0000);
        nrec = 0;
        @(negedge clk);
        chk("restart", {done, busy}, 2'b01);
        t0 = $time - 5;
        start = 1'b0;
        wait_done();
        end_checks(1280);

        // Single vector, zero settle.
        @(posedge clk);
        #1 s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("small_rec", {s_rec_valid, s_rec_a, s_rec_b, s_rec_out, s_rec_mismatch, s_done},
            {1'b1, 16'h0000, B, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        chk("small_done", {s_done, s_pass, s_busy, s_rec_valid, s_err_count, s_first_err_valid},
            {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0});
        repeat (3) @(negedge clk);
        chk("small_single", {s_rec_valid, s_done, s_busy}, 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
